// File: rtl/mic_meter_pkg.sv
// Shared types and LED encoding helpers for the microphone level meter.
// The encoders are pure functions, so they can be reused outside the meter.
package mic_meter_pkg;

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        UPDATE  = 2'd1,
        PUBLISH = 2'd2
    } state_t;

    typedef enum logic {
        BAR_THERMO = 1'b0,
        BAR_ONEHOT = 1'b1
    } bar_mode_t;

    localparam int LED_W = 16;

    // Bit i is lit when value >= 2**i, i.e. value has any bit set at or above i.
    function automatic logic [LED_W-1:0] thermo16(input logic [LED_W-1:0] value);
        logic [LED_W-1:0] bar;
        bar = '0;
        for (int i = 0; i < LED_W; i++) begin
            bar[i] = ((value >> i) != '0);
        end
        return bar;
    endfunction

    function automatic logic [LED_W-1:0] onehot_msb16(input logic [LED_W-1:0] value);
        logic [LED_W-1:0] onehot;
        onehot = '0;
        for (int i = 0; i < LED_W; i++) begin
            if (value[i]) begin
                onehot = '0;
                onehot[i] = 1'b1;
            end
        end
        return onehot;
    endfunction

endpackage

// File: rtl/level_to_bar.sv
// Combinational LED encoder: either a log-scale thermometer bar or a one-hot
// marker at the leading one of the input magnitude.
module level_to_bar
    import mic_meter_pkg::*;
#(
    parameter bar_mode_t MODE = BAR_THERMO
) (
    input  logic [15:0] value,
    output logic [15:0] leds
);

    always_comb begin
        // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
        leds = '0;
        if (MODE == BAR_THERMO) begin
            leds = thermo16(value);
        end else begin
            leds = onehot_msb16(value);
        end
    end

endmodule

// File: rtl/mic_level_meter.sv
// Windowed peak envelope of a signed PCM stream with decay, peak-hold and clip
// detection, published once per window to a 16-LED log bar and a peak LED.
module mic_level_meter
    import mic_meter_pkg::*;
#(
    parameter int          WINDOW       = 256,
    parameter int          DECAY_SHIFT  = 3,
    parameter int          HOLD_WINDOWS = 8,
    parameter logic [15:0] CLIP_THRESH  = 16'd32000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] sample_data,
    input  logic        sample_valid,
    output logic [15:0] level,
    output logic [15:0] peak,
    output logic [15:0] led_bar,
    output logic [15:0] led_peak,
    output logic        clip,
    output logic        level_valid
);

    localparam int CNT_W  = $clog2(WINDOW);
    localparam int HOLD_W = $clog2(HOLD_WINDOWS + 1);

    state_t            state;
    logic [CNT_W-1:0]  win_cnt;
    logic [15:0]       win_max;
    logic              win_clip;
    logic [15:0]       closed_max;
    logic              closed_clip;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] clip_cnt;

    logic [15:0] mag;
    logic [15:0] sample_max;
    logic        sample_clip;
    logic        win_close;
    logic [15:0] level_decay;
    logic [15:0] level_next;
    logic [15:0] level_bar;
    logic [15:0] peak_onehot;

    // -32768 maps to 32768, which still fits the unsigned 16-bit magnitude.
    always_comb begin
        mag         = sample_data[15] ? (~sample_data + 16'd1) : sample_data;
        sample_max  = (mag > win_max) ? mag : win_max;
        sample_clip = (mag >= CLIP_THRESH);
        win_close   = sample_valid && (win_cnt == CNT_W'(WINDOW - 1));
    end

    always_comb begin
        level_decay = level >> DECAY_SHIFT;
        level_next  = level;
        if (closed_max >= level) begin
            level_next = closed_max;
        end else if (level_decay != '0) begin
            level_next = level - level_decay;
        end else if (level != '0) begin
            // Small levels shift to zero decay; step down by one so they still reach 0.
            level_next = level - 16'd1;
        end
    end

    // Accumulation runs in every FSM state so samples during UPDATE/PUBLISH land in the new window.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous here, so it is tested inside the clocked block rather than in the sensitivity list.
        if (!reset_n) begin
            win_cnt     <= '0;
            win_max     <= '0;
            win_clip    <= 1'b0;
            closed_max  <= '0;
            closed_clip <= 1'b0;
        end else if (sample_valid) begin
            if (win_close) begin
                closed_max  <= sample_max;
                closed_clip <= win_clip | sample_clip;
                win_cnt     <= '0;
                win_max     <= '0;
                win_clip    <= 1'b0;
            end else begin
                win_cnt     <= win_cnt + CNT_W'(1);
                win_max     <= sample_max;
                win_clip    <= win_clip | sample_clip;
            end
        end
    end

    level_to_bar #(.MODE(BAR_THERMO)) u_level_bar (
        .value (level),
        .leds  (level_bar)
    );

    level_to_bar #(.MODE(BAR_ONEHOT)) u_peak_bar (
        .value (peak),
        .leds  (peak_onehot)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= ACCUM;
            level       <= '0;
            peak        <= '0;
            hold_cnt    <= '0;
            clip        <= 1'b0;
            clip_cnt    <= '0;
            led_bar     <= '0;
            led_peak    <= '0;
            level_valid <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            level_valid <= 1'b0;
            case (state)
                ACCUM: begin
                    if (win_close) begin
                        state <= UPDATE;
                    end
                end
                UPDATE: begin
                    level <= level_next;
                    if (closed_max >= peak) begin
                        peak     <= closed_max;
                        hold_cnt <= HOLD_W'(HOLD_WINDOWS);
                    end else if (hold_cnt == '0) begin
                        peak <= level_next;
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end
                    if (closed_clip) begin
                        clip     <= 1'b1;
                        clip_cnt <= HOLD_W'(HOLD_WINDOWS);
                    end else if (clip_cnt == '0) begin
                        clip <= 1'b0;
                    end else begin
                        clip_cnt <= clip_cnt - HOLD_W'(1);
                    end
                    state <= PUBLISH;
                end
                PUBLISH: begin
                    led_bar     <= level_bar;
                    led_peak    <= peak_onehot;
                    level_valid <= 1'b1;
                    state       <= ACCUM;
                end
                default: begin
                    state <= ACCUM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mic_level_meter.sv
// Directed bench for mic_level_meter with WINDOW=4, DECAY_SHIFT=2,
// HOLD_WINDOWS=3; expected values are hand-computed constants.
module tb_mic_level_meter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] sample_data = '0;
    logic        sample_valid = 1'b0;
    logic [15:0] level;
    logic [15:0] peak;
    logic [15:0] led_bar;
    logic [15:0] led_peak;
    logic        clip;
    logic        level_valid;

    int tests = 0;
    int fails = 0;

    logic [15:0] b2b [12];

    always #5 clk = ~clk;

    mic_level_meter #(
        .WINDOW       (4),
        .DECAY_SHIFT  (2),
        .HOLD_WINDOWS (3),
        .CLIP_THRESH  (16'd32000)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .level        (level),
        .peak         (peak),
        .led_bar      (led_bar),
        .led_peak     (led_peak),
        .clip         (clip),
        .level_valid  (level_valid)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, observed, observed, expected, expected);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, " level"},       32'(level),       32'd0);
        check({tag, " peak"},        32'(peak),        32'd0);
        check({tag, " led_bar"},     32'(led_bar),     32'd0);
        check({tag, " led_peak"},    32'(led_peak),    32'd0);
        check({tag, " clip"},        32'(clip),        32'd0);
        check({tag, " level_valid"}, 32'(level_valid), 32'd0);
    endtask

    // Inputs change on the falling edge; the DUT samples them on the next rising edge.
    task automatic send(input logic [15:0] v);
        sample_data  = v;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        sample_data  = '0;
    endtask

    task automatic send_window(input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] c, input logic [15:0] d);
        send(a);
        send(b);
        send(c);
        send(d);
    endtask

    // Called one falling edge after the closing sample: pulse must appear exactly two edges after it.
    task automatic expect_publish(input string tag, input logic [15:0] exp_level, input logic [15:0] exp_peak,
                                  input logic [15:0] exp_bar, input logic [15:0] exp_lpk, input logic exp_clip);
        check({tag, " lv+1"}, 32'(level_valid), 32'd0);
        @(negedge clk);
        check({tag, " lv+2"}, 32'(level_valid), 32'd0);
        @(negedge clk);
        check({tag, " lv+3"},     32'(level_valid), 32'd1);
        check({tag, " level"},    32'(level),       32'(exp_level));
        check({tag, " peak"},     32'(peak),        32'(exp_peak));
        check({tag, " led_bar"},  32'(led_bar),     32'(exp_bar));
        check({tag, " led_peak"}, 32'(led_peak),    32'(exp_lpk));
        check({tag, " clip"},     32'(clip),        32'(exp_clip));
        @(negedge clk);
        check({tag, " lv pulse end"}, 32'(level_valid), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        check_zero(tag);
    endtask

    initial begin
        b2b = '{16'd10, 16'd20, 16'd30, 16'd40,
                16'd100, 16'hFE0C, 16'd3, 16'd4,
                16'd7, 16'hFFF8, 16'd1, 16'd2};

        // Reset with random traffic: nothing may leak through.
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample_valid = 1'($urandom_range(0, 1));
            sample_data  = 16'($urandom);
            @(negedge clk);
            check_zero("reset");
        end
        sample_valid = 1'b0;
        sample_data  = '0;
        reset_n      = 1'b1;
        @(negedge clk);
        check_zero("post reset");

        // Basic window, then full-scale negative clip with hold and release.
        send_window(16'd100, 16'hFED4, 16'd50, 16'd0);
        expect_publish("w1", 16'd300, 16'd300, 16'h01FF, 16'h0100, 1'b0);
        send_window(16'd0, 16'h8000, 16'd5, 16'd0);
        expect_publish("clip", 16'd32768, 16'd32768, 16'hFFFF, 16'h8000, 1'b1);
        send_window(16'd0, 16'd0, 16'd0, 16'd0);
        expect_publish("clip s1", 16'd24576, 16'd32768, 16'h7FFF, 16'h8000, 1'b1);
        send_window(16'd0, 16'd0, 16'd0, 16'd0);
        expect_publish("clip s2", 16'd18432, 16'd32768, 16'h7FFF, 16'h8000, 1'b1);
        send_window(16'd0, 16'd0, 16'd0, 16'd0);
        expect_publish("clip s3", 16'd13824, 16'd32768, 16'h3FFF, 16'h8000, 1'b1);
        send_window(16'd0, 16'd0, 16'd0, 16'd0);
        expect_publish("clip s4", 16'd10368, 16'd10368, 16'h3FFF, 16'h2000, 1'b0);

        // Clip threshold boundary: 31999 stays clear, -32000 sets clip.
        do_reset("rst thresh");
        send_window(16'd31999, 16'd0, 16'd0, 16'd0);
        expect_publish("thr below", 16'd31999, 16'd31999, 16'h7FFF, 16'h4000, 1'b0);
        send_window(16'd0, 16'd0, 16'h8300, 16'd0);
        expect_publish("thr at", 16'd32000, 16'd32000, 16'h7FFF, 16'h4000, 1'b1);

        // Shift decay with peak hold for three windows, then peak follows level.
        do_reset("rst decay");
        send_window(16'hFC00, 16'd12, 16'd0, 16'd1000);
        expect_publish("d1024", 16'd1024, 16'd1024, 16'h07FF, 16'h0400, 1'b0);
        send_window(16'd0, 16'd0, 16'd0, 16'd0);
        expect_publish("d768", 16'd768, 16'd1024, 16'h03FF, 16'h0400, 1'b0);
        send_window(16'd0, 16'd0, 16'd0, 16'd0);
        expect_publish("d576", 16'd576, 16'd1024, 16'h03FF, 16'h0400, 1'b0);
        send_window(16'd0, 16'd0, 16'd0, 16'd0);
        expect_publish("d432", 16'd432, 16'd1024, 16'h01FF, 16'h0400, 1'b0);
        send_window(16'd0, 16'd0, 16'd0, 16'd0);
        expect_publish("d324", 16'd324, 16'd324, 16'h01FF, 16'h0100, 1'b0);

        // Decay floor: small levels step down by one and settle at zero.
        do_reset("rst floor");
        send_window(16'd1, 16'hFFFD, 16'd2, 16'd0);
        expect_publish("f3", 16'd3, 16'd3, 16'h0003, 16'h0002, 1'b0);
        send_window(16'd0, 16'd0, 16'd0, 16'd0);
        expect_publish("f2", 16'd2, 16'd3, 16'h0003, 16'h0002, 1'b0);
        send_window(16'd0, 16'd0, 16'd0, 16'd0);
        expect_publish("f1", 16'd1, 16'd3, 16'h0001, 16'h0002, 1'b0);
        send_window(16'd0, 16'd0, 16'd0, 16'd0);
        expect_publish("f0", 16'd0, 16'd3, 16'h0000, 16'h0002, 1'b0);
        send_window(16'd0, 16'd0, 16'd0, 16'd0);
        expect_publish("f0 again", 16'd0, 16'd0, 16'h0000, 16'h0000, 1'b0);

        // Back-to-back samples across UPDATE/PUBLISH: windows close every 4 valids.
        do_reset("rst b2b");
        for (int i = 0; i < 14; i++) begin
            if (i < 12) begin
                sample_valid = 1'b1;
                sample_data  = b2b[i];
            end else begin
                sample_valid = 1'b0;
                sample_data  = '0;
            end
            @(negedge clk);
            check($sformatf("b2b lv c%0d", i), 32'(level_valid), 32'((i == 5) || (i == 9) || (i == 13)));
            if (i == 5)  check("b2b level A", 32'(level), 32'd40);
            if (i == 9)  check("b2b level B", 32'(level), 32'd500);
            if (i == 13) check("b2b level C", 32'(level), 32'd375);
        end
        check("b2b peak", 32'(peak), 32'd500);

        // Reset mid-window discards the partial samples; next window needs 4 new samples.
        send(16'd111);
        send(16'd222);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check_zero("mid reset");
        send(16'd5);
        send(16'd6);
        send(16'd7);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("mid reset quiet %0d", i), 32'(level_valid), 32'd0);
            @(negedge clk);
        end
        send(16'd9);
        expect_publish("after reset", 16'd9, 16'd9, 16'h000F, 16'h0008, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
